// File: rtl/bcd_pkg.sv
// Shared types and constant helpers for the sequential binary-to-BCD converter.
// Digit-count helpers serve both elaboration sizing checks and the output formatter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    // Upper bound on DIGITS so the significant-digit helper can take a fixed-width vector.
    localparam int BCD_MAX_DIGITS = 32;

    // Smallest d with 10^d >= 2^width, i.e. enough digits for any width-bit magnitude.
    function automatic int bcd_min_digits(input int width);
        logic [255:0] limit;
        logic [255:0] pow10;
        int d;
        limit = 256'd1 << width;
        pow10 = 256'd1;
        d = 0;
        while (pow10 < limit) begin
            pow10 = pow10 * 256'd10;
            d++;
        end
        return d;
    endfunction

    function automatic int bcd_sig_digits(input logic [4*BCD_MAX_DIGITS-1:0] bcd,
                                          input int digits);
        int n;
        n = 1;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            if (i < digits && bcd[4*i +: 4] != 4'd0) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_dabble_stage.sv
// One BCD digit of the double-dabble correction: a nibble of 5 or more gets +3
// so that the following left shift carries correctly into the next decimal digit.
module bcd_dabble_stage (
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = nibble;
        if (nibble >= 4'd5) begin
            adjusted = nibble + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter, one input bit per clock, with valid/ready on both
// sides, optional two's-complement input and a count of significant digits.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 24,
    parameter int DIGITS = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BIN_W-1:0]             in_bin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4*DIGITS-1:0]          out_bcd,
    output logic                         out_neg,
    output logic [$clog2(DIGITS+1)-1:0]  out_ndigits,
    output logic                         busy
);

    import bcd_pkg::*;

    localparam int ACC_W = 4 * DIGITS;
    localparam int NDW   = $clog2(DIGITS + 1);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int MAG_W = SIGNED ? BIN_W - 1 : BIN_W;

    if (BIN_W < 2) begin : g_bad_width
        $error("bin_to_bcd_seq: BIN_W must be at least 2");
    end
    if (DIGITS > BCD_MAX_DIGITS) begin : g_too_many_digits
        $error("bin_to_bcd_seq: DIGITS exceeds BCD_MAX_DIGITS");
    end
    if (DIGITS < bcd_min_digits(MAG_W)) begin : g_too_few_digits
        $error("bin_to_bcd_seq: DIGITS too small for the input magnitude range");
    end

    bcd_state_t                  state;
    logic [BIN_W-1:0]            sreg;
    logic [BIN_W-1:0]            magnitude;
    logic                        neg;
    logic                        neg_next;
    logic [CNT_W-1:0]            cnt;
    logic [ACC_W-1:0]            acc;
    logic [ACC_W-1:0]            adj;
    logic [ACC_W-1:0]            acc_next;
    logic [4*BCD_MAX_DIGITS-1:0] acc_pad;
    logic [NDW-1:0]              ndigits_next;
    logic                        unused_top;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_dabble_stage u_stage (
            .nibble   (acc[4*i +: 4]),
            .adjusted (adj[4*i +: 4])
        );
    end

    // Negating the most-negative value wraps to 2^(BIN_W-1), which is exactly the magnitude wanted.
    always_comb begin
        neg_next  = SIGNED && in_bin[BIN_W-1];
        magnitude = in_bin;
        if (neg_next) begin
            magnitude = ~in_bin + 1'b1;
        end
    end

    // The top adjusted bit can never be set for a correctly sized DIGITS, so it is dropped.
    always_comb begin
        acc_next   = {adj[ACC_W-2:0], sreg[BIN_W-1]};
        unused_top = adj[ACC_W-1];
        acc_pad    = '0;
        acc_pad[ACC_W-1:0] = acc_next;
        ndigits_next = NDW'(bcd_sig_digits(acc_pad, DIGITS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sreg        <= '0;
            acc         <= '0;
            cnt         <= '0;
            neg         <= 1'b0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_bcd     <= '0;
            out_neg     <= 1'b0;
            out_ndigits <= NDW'(1);
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state    <= SHIFT;
                        sreg     <= magnitude;
                        neg      <= neg_next;
                        acc      <= '0;
                        cnt      <= CNT_W'(BIN_W);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    acc  <= acc_next;
                    sreg <= {sreg[BIN_W-2:0], 1'b0};
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        out_bcd     <= acc_next;
                        out_neg     <= neg && (acc_next != '0);
                        out_ndigits <= ndigits_next;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
